// File: rtl/vanilla_pkg.sv
// ---------------------------------------------------------------------------
// vanilla_pkg
// Shared types and constants for the FPro MMIO subsystem.
//   DATA_WIDTH / MMIO_ADDR_WIDTH : system bus widths (data word, word address)
//   NUM_SLOTS / SLOT_W / REG_W   : default slot count, slot index width and
//                                  per-slot register offset width
//   state_t                      : WISHBONE-to-MMIO controller FSM states
//   slot_data_t                  : per-slot read data array
// ---------------------------------------------------------------------------
package vanilla_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int MMIO_ADDR_WIDTH = 21;

    localparam int NUM_SLOTS = 64;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);
    localparam int REG_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        ACK,
        HOLD
    } state_t;

    typedef logic [DATA_WIDTH-1:0] slot_data_t [NUM_SLOTS];

endpackage

// File: rtl/mmio_slot_decoder.sv
// ---------------------------------------------------------------------------
// mmio_slot_decoder
// Combinational slot index -> one-hot chip select.
//   slot : slot index
//   en   : decode enable; cs is all-zero when low
//   cs   : one-hot chip select; all-zero for an index >= NUM_SLOTS
// ---------------------------------------------------------------------------
module mmio_slot_decoder #(
    parameter int NUM_SLOTS = 64,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic [SLOT_W-1:0]    slot,
    input  logic                 en,
    output logic [NUM_SLOTS-1:0] cs
);

    // Comparing every slot position against the index leaves out-of-range
    // indices with no select at all, without a separate range check.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cs[i] = en && (int'(slot) == i);
        end
    end

endmodule

// File: rtl/wb_mmio_controller.sv
// ---------------------------------------------------------------------------
// wb_mmio_controller
// Classic WISHBONE slave that turns each bus cycle into one single-cycle
// FPro MMIO access with a fixed 3-cycle request-to-ACK latency.
//   clk, reset_n        : clock, asynchronous active-low reset
//   CYC_I/STB_I/WE_I    : WISHBONE cycle, strobe, write enable
//   ADDR_I              : word address {ignored, slot, register}
//   DAT_I / DAT_O       : write data in / read data out (valid with ACK_O)
//   ACK_O               : one-cycle transfer acknowledge
//   mmio_cs             : one-hot slot select (ACCESS cycle only)
//   mmio_rd / mmio_wr   : single-cycle read / write strobes
//   mmio_addr           : register offset within the slot
//   mmio_wr_data        : write data to the slots
//   mmio_rd_data        : per-slot read data
// ---------------------------------------------------------------------------
module wb_mmio_controller
    import vanilla_pkg::*;
#(
    parameter int NUM_SLOTS = vanilla_pkg::NUM_SLOTS,
    parameter int REG_W     = vanilla_pkg::REG_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       CYC_I,
    input  logic                       STB_I,
    input  logic                       WE_I,
    input  logic [MMIO_ADDR_WIDTH-1:0] ADDR_I,
    input  logic [DATA_WIDTH-1:0]      DAT_I,
    output logic [DATA_WIDTH-1:0]      DAT_O,
    output logic                       ACK_O,
    output logic [NUM_SLOTS-1:0]       mmio_cs,
    output logic                       mmio_rd,
    output logic                       mmio_wr,
    output logic [REG_W-1:0]           mmio_addr,
    output logic [DATA_WIDTH-1:0]      mmio_wr_data,
    input  logic [DATA_WIDTH-1:0]      mmio_rd_data [NUM_SLOTS]
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);

    state_t                  state, state_next;
    logic [SLOT_W-1:0]       slot_q;
    logic [REG_W-1:0]        reg_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    req;
    logic                    slot_valid;
    logic                    strobe;
    logic                    busy;

    // Address bits above the slot field carry no meaning for this block.
    logic addr_unused;
    assign addr_unused = ^ADDR_I[MMIO_ADDR_WIDTH-1:REG_W+SLOT_W];

    assign req        = CYC_I && STB_I;
    assign slot_valid = int'(slot_q) < NUM_SLOTS;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every output of this block is given a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req)            state_next = ACCESS;
            ACCESS:  state_next = CYC_I ? CAPTURE : IDLE;
            CAPTURE: state_next = CYC_I ? ACK     : IDLE;
            ACK:     state_next = HOLD;
            HOLD:    if (!STB_I || !CYC_I) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the request registers are few and flat, so they take the async
    // reset too; that keeps mmio_addr/mmio_wr_data defined from power-up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= '0;
            reg_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && req) begin
                slot_q  <= ADDR_I[REG_W+SLOT_W-1:REG_W];
                reg_q   <= ADDR_I[REG_W-1:0];
                we_q    <= WE_I;
                wdata_q <= DAT_I;
            end
            // Slot read data is valid the cycle after its chip select.
            if (state == CAPTURE && CYC_I && !we_q) begin
                rdata_q <= slot_valid ? mmio_rd_data[slot_q] : '0;
            end
        end
    end

    assign strobe = (state == ACCESS) && slot_valid;
    assign busy   = (state == ACCESS) || (state == CAPTURE) || (state == ACK);

    mmio_slot_decoder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_slot_decoder (
        .slot (slot_q),
        .en   (strobe),
        .cs   (mmio_cs)
    );

    always_comb begin
        mmio_rd      = strobe && !we_q;
        mmio_wr      = strobe && we_q;
        mmio_addr    = busy ? reg_q   : '0;
        mmio_wr_data = busy ? wdata_q : '0;
        ACK_O        = (state == ACK);
        DAT_O        = (state == ACK && !we_q) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_wb_mmio_controller.sv
// ---------------------------------------------------------------------------
// tb_wb_mmio_controller
// Self-checking bench for wb_mmio_controller. Slot read data comes from a
// fixed table; expected DAT_O values are queued when a request is driven and
// popped when ACK_O is seen.
// ---------------------------------------------------------------------------
module tb_wb_mmio_controller;
    import vanilla_pkg::*;

    logic                       clk;
    logic                       reset_n;
    logic                       CYC_I;
    logic                       STB_I;
    logic                       WE_I;
    logic [MMIO_ADDR_WIDTH-1:0] ADDR_I;
    logic [DATA_WIDTH-1:0]      DAT_I;
    logic [DATA_WIDTH-1:0]      DAT_O;
    logic                       ACK_O;
    logic [NUM_SLOTS-1:0]       mmio_cs;
    logic                       mmio_rd;
    logic                       mmio_wr;
    logic [REG_W-1:0]           mmio_addr;
    logic [DATA_WIDTH-1:0]      mmio_wr_data;
    slot_data_t                 slot_mem;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_WIDTH-1:0] exp_q [$];

    wb_mmio_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .CYC_I        (CYC_I),
        .STB_I        (STB_I),
        .WE_I         (WE_I),
        .ADDR_I       (ADDR_I),
        .DAT_I        (DAT_I),
        .DAT_O        (DAT_O),
        .ACK_O        (ACK_O),
        .mmio_cs      (mmio_cs),
        .mmio_rd      (mmio_rd),
        .mmio_wr      (mmio_wr),
        .mmio_addr    (mmio_addr),
        .mmio_wr_data (mmio_wr_data),
        .mmio_rd_data (slot_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request at a negedge and checks every cycle from the ACCESS
    // cycle (idx 0) through HOLD, with STB_I kept high for 'hold' extra cycles.
    task automatic run_txn(input logic we, input logic [MMIO_ADDR_WIDTH-1:0] addr,
                           input logic [DATA_WIDTH-1:0] wdata, input int hold,
                           input string name);
        logic [SLOT_W-1:0]     slot;
        logic [REG_W-1:0]      rg;
        logic [NUM_SLOTS-1:0]  one_hot;
        logic [NUM_SLOTS-1:0]  exp_cs;
        logic [DATA_WIDTH-1:0] exp_dat;
        logic [DATA_WIDTH-1:0] got_exp;
        logic                  exp_rd, exp_wr, exp_ack;
        logic [REG_W-1:0]      exp_addr;
        logic [DATA_WIDTH-1:0] exp_wd;
        slot    = addr[REG_W+SLOT_W-1:REG_W];
        rg      = addr[REG_W-1:0];
        one_hot = '0;
        one_hot[slot] = 1'b1;
        exp_dat = we ? '0 : slot_mem[slot];
        exp_q.push_back(exp_dat);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADDR_I = addr; DAT_I = wdata;
        for (int i = 0; i < 4 + hold; i++) begin
            @(negedge clk);
            exp_rd   = (i == 0) && !we;
            exp_wr   = (i == 0) && we;
            exp_cs   = (i == 0) ? one_hot : '0;
            exp_ack  = (i == 2);
            exp_addr = (i <= 2) ? rg    : '0;
            exp_wd   = (i <= 2) ? wdata : '0;
            n_checks++;
            if ({mmio_rd, mmio_wr} !== {exp_rd, exp_wr}) begin
                n_fail++;
                $display("FAIL %s strobe cyc%0d: rd/wr=%b%b expected %b%b",
                         name, i, mmio_rd, mmio_wr, exp_rd, exp_wr);
            end
            n_checks++;
            if (mmio_cs !== exp_cs) begin
                n_fail++;
                $display("FAIL %s cs cyc%0d: got %h expected %h", name, i, mmio_cs, exp_cs);
            end
            n_checks++;
            if (mmio_addr !== exp_addr || mmio_wr_data !== exp_wd) begin
                n_fail++;
                $display("FAIL %s addr/wdata cyc%0d: got %h/%h expected %h/%h",
                         name, i, mmio_addr, mmio_wr_data, exp_addr, exp_wd);
            end
            n_checks++;
            if (ACK_O !== exp_ack) begin
                n_fail++;
                $display("FAIL %s ack cyc%0d: got %b expected %b", name, i, ACK_O, exp_ack);
            end
            if (ACK_O === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s dat: ACK with empty scoreboard, DAT_O=%h", name, DAT_O);
                end else begin
                    got_exp = exp_q.pop_front();
                    if (DAT_O !== got_exp) begin
                        n_fail++;
                        $display("FAIL %s dat: got %h expected %h", name, DAT_O, got_exp);
                    end
                end
            end
        end
        STB_I = 1'b0;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || ACK_O !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: pending=%0d ack=%b expected 0 and 0",
                     name, exp_q.size(), ACK_O);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
        ADDR_I = 21'h000A3; DAT_I = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        n_checks++;
        if (DAT_O !== '0 || ACK_O !== 1'b0 || mmio_cs !== '0 || mmio_rd !== 1'b0 ||
            mmio_wr !== 1'b0 || mmio_addr !== '0 || mmio_wr_data !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: dat=%h ack=%b cs=%h rd=%b wr=%b addr=%h wd=%h expected all 0",
                     DAT_O, ACK_O, mmio_cs, mmio_rd, mmio_wr, mmio_addr, mmio_wr_data);
        end
        // Release with the request already up: first edge afterwards is edge 0.
        reset_n = 1'b1;
        run_txn(1'b0, 21'h00041, 32'h0, 0, "reset_release_read");
    endtask

    task automatic test_write();
        run_txn(1'b1, 21'h000A3, 32'hDEAD_BEEF, 0, "write");
    endtask

    task automatic test_read();
        run_txn(1'b0, 21'h007E0, 32'h0, 0, "read");
        run_txn(1'b0, 21'h0005F, 32'h0, 0, "read_slot2_reg31");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 21'h00124, 32'h0BAD_F00D, 10, "stb_held");
        run_txn(1'b0, 21'h00124, 32'h0, 0, "after_stb_drop");
    endtask

    task automatic test_abort();
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0; ADDR_I = 21'h00300; DAT_I = '0;
        @(negedge clk);
        n_checks++;
        if (mmio_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL abort strobe: rd=%b expected 1", mmio_rd);
        end
        @(negedge clk);
        CYC_I = 1'b0; STB_I = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (ACK_O !== 1'b0 || mmio_rd !== 1'b0) begin
                n_fail++;
                $display("FAIL abort cyc%0d: ack=%b rd=%b expected 0 0", i, ACK_O, mmio_rd);
            end
        end
        run_txn(1'b0, 21'h00300, 32'h0, 0, "after_abort");
    endtask

    task automatic test_reset_mid_op();
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADDR_I = 21'h00065; DAT_I = 32'h5555_AAAA;
        @(negedge clk);
        n_checks++;
        if (mmio_wr !== 1'b1 || mmio_cs === '0) begin
            n_fail++;
            $display("FAIL midrst access: wr=%b cs=%h expected 1 and nonzero", mmio_wr, mmio_cs);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (mmio_wr !== 1'b0 || mmio_cs !== '0) begin
            n_fail++;
            $display("FAIL midrst async: wr=%b cs=%h expected 0 and 0", mmio_wr, mmio_cs);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (ACK_O !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst ack cyc%0d: got %b expected 0", i, ACK_O);
            end
        end
        CYC_I = 1'b0; STB_I = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 21'h0001F, 32'h0, 0, "midrst_read_slot0");
    endtask

    initial begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_mem[i] = 32'hA500_0000 | (32'(i) << 8) | 32'(i);
        end
        slot_mem[63] = 32'h1234_5678;
        reset_n = 1'b0;
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADDR_I = '0; DAT_I = '0;
        @(negedge clk);

        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_abort();
        test_reset_mid_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
